ex_core_rom_bist: RTL and testbench

EX_CORE_ROM_BIST -- requirements
Module: ex_core_rom_bist

---
 rtl/ex_core_pkg.sv | 15 +
 rtl/ex_core_rom_bist.sv | 97 +++++++++
 tb/tb_ex_core_rom_bist.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_core_pkg.sv
// Shared types and default widths for the ROM BIST engine.
package ex_core_pkg;

  localparam int EX_ADDR_W = 8;
  localparam int EX_DATA_W = 8;
  localparam int EX_SIG_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } bist_state_e;

endpackage

// File: rtl/ex_core_rom_bist.sv
// ROM BIST: additive signature over addresses 0..EndAddr, Done EndAddr+3 cycles after start.
// No backpressure; abort wins over start, and functional ROM access is muxed through while not busy.
module ex_core_rom_bist
  import ex_core_pkg::*;
#(
  parameter int ADDR_W = EX_ADDR_W,
  parameter int DATA_W = EX_DATA_W,
  parameter int SIG_W  = EX_SIG_W
) (
  input  logic              WRCK,
  input  logic              WRSTN,
  input  logic              BistStart,
  input  logic              BistAbort,
  input  logic [ADDR_W-1:0] EndAddr,
  input  logic [SIG_W-1:0]  Golden,
  input  logic [ADDR_W-1:0] FuncAddress,
  input  logic [DATA_W-1:0] RomDataIn,
  output logic [ADDR_W-1:0] RomAddress,
  output logic [DATA_W-1:0] FuncDataOut,
  output logic              BistBusy,
  output logic              BistDone,
  output logic              BistPass,
  output logic [SIG_W-1:0]  Signature
);

  bist_state_e       state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] end_q;
  logic [SIG_W-1:0]  sig_q;
  logic [SIG_W-1:0]  golden_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [SIG_W-1:0]  sig_d;

  assign sig_d = sig_q + SIG_W'(RomDataIn);

  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      end_q    <= '0;
      sig_q    <= '0;
      golden_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else if (BistAbort) begin
      // Signature is deliberately left untouched so it can be inspected after an abort.
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (BistStart) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            sig_q    <= '0;
            end_q    <= EndAddr;
            golden_q <= Golden;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          sig_q <= sig_d;
          cnt_q <= cnt_q + ADDR_W'(1);
          // Compare before increment so EndAddr of all-ones never depends on wrap.
          if (cnt_q == end_q) begin
            state_q <= ST_CMP;
          end
        end
        ST_CMP: begin
          pass_q  <= (sig_q == golden_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign RomAddress  = busy_q ? cnt_q : FuncAddress;
  assign FuncDataOut = busy_q ? '0 : RomDataIn;
  assign BistBusy    = busy_q;
  assign BistDone    = done_q;
  assign BistPass    = pass_q;
  assign Signature   = sig_q;

endmodule

// File: tb/tb_ex_core_rom_bist.sv
// Bench for ex_core_rom_bist: behavioural ROM beside the DUT, table vectors, corner sequences, random runs.
module tb_ex_core_rom_bist;

  logic        WRCK;
  logic        WRSTN;
  logic        BistStart;
  logic        BistAbort;
  logic [7:0]  EndAddr;
  logic [15:0] Golden;
  logic [7:0]  FuncAddress;
  logic [7:0]  RomDataIn;
  logic [7:0]  RomAddress;
  logic [7:0]  FuncDataOut;
  logic        BistBusy;
  logic        BistDone;
  logic        BistPass;
  logic [15:0] Signature;

  logic [7:0] rom_mem [256];
  int checks = 0;
  int failures = 0;

  assign RomDataIn = rom_mem[RomAddress];

  ex_core_rom_bist #(.ADDR_W(8), .DATA_W(8), .SIG_W(16)) dut (
    .WRCK(WRCK), .WRSTN(WRSTN), .BistStart(BistStart), .BistAbort(BistAbort),
    .EndAddr(EndAddr), .Golden(Golden), .FuncAddress(FuncAddress), .RomDataIn(RomDataIn),
    .RomAddress(RomAddress), .FuncDataOut(FuncDataOut), .BistBusy(BistBusy),
    .BistDone(BistDone), .BistPass(BistPass), .Signature(Signature)
  );

  initial WRCK = 1'b0;
  always #5 WRCK = ~WRCK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  ea;
    logic [15:0] gd;
    int          repulse;
    logic [15:0] sig;
    logic        pass;
    int          done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge WRCK);
    #2;
  endtask

  task automatic identity_rom();
    for (int a = 0; a < 256; a++) rom_mem[a] = 8'(a);
  endtask

  // Cycle 1 is the first sample after the edge that takes the start pulse.
  task automatic run_bist(input logic [7:0] ea, input logic [15:0] gd, input int repulse,
                          output int done_cyc, output int busy_cyc, output int bus_err);
    int cyc;
    EndAddr = ea;
    Golden = gd;
    BistStart = 1'b1;
    tick();
    BistStart = 1'b0;
    EndAddr = 8'($urandom);
    Golden = 16'($urandom);
    cyc = 1;
    busy_cyc = 0;
    bus_err = 0;
    done_cyc = -1;
    while (cyc < 600) begin
      FuncAddress = 8'($urandom);
      #1;
      if (BistDone) begin
        done_cyc = cyc;
        break;
      end
      if (BistBusy) busy_cyc++;
      if (cyc <= int'(ea) + 1 && int'(RomAddress) != cyc - 1) bus_err++;
      if (BistBusy && FuncDataOut != 8'h00) bus_err++;
      BistStart = (cyc == repulse);
      tick();
      cyc++;
    end
    BistStart = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int done_cyc);
    int cyc;
    cyc = 1;
    done_cyc = -1;
    while (cyc < bound) begin
      #1;
      if (BistDone) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  vec_t vt[6];
  int done_cyc, busy_cyc, bus_err, stray;
  int model_sum;
  logic [7:0]  r_ea;
  logic [15:0] r_gd;
  logic        r_pass;

  initial begin
    vt[0] = '{8'hFF, 16'h7F80,   0, 16'h7F80, 1'b1, 258};
    vt[1] = '{8'h0F, 16'h0078,   0, 16'h0078, 1'b1,  18};
    vt[2] = '{8'hFF, 16'h7F81,   0, 16'h7F80, 1'b0, 258};
    vt[3] = '{8'h00, 16'h0000,   0, 16'h0000, 1'b1,   3};
    vt[4] = '{8'h0F, 16'h0078,   5, 16'h0078, 1'b1,  18};
    vt[5] = '{8'h10, 16'h0088,  18, 16'h0088, 1'b1,  19};

    identity_rom();
    WRSTN = 1'b1;
    BistStart = 1'b0;
    BistAbort = 1'b0;
    EndAddr = 8'h00;
    Golden = 16'h0000;
    FuncAddress = 8'h33;
    #3 WRSTN = 1'b0;
    #1;
    check("rst_busy", 32'(BistBusy), 0);
    check("rst_done", 32'(BistDone), 0);
    check("rst_pass", 32'(BistPass), 0);
    check("rst_sig", 32'(Signature), 0);
    check("rst_romaddr", 32'(RomAddress), 32'h33);
    check("rst_funcdata", 32'(FuncDataOut), 32'h33);
    BistStart = 1'b1;
    tick();
    BistStart = 1'b0;
    #1 check("rst_start_ignored", 32'(BistBusy), 0);
    tick();
    WRSTN = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_bist(vt[i].ea, vt[i].gd, vt[i].repulse, done_cyc, busy_cyc, bus_err);
      check($sformatf("vec%0d_done_cycle", i), 32'(done_cyc), 32'(vt[i].done));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cyc), 32'(vt[i].done - 1));
      check($sformatf("vec%0d_sig", i), 32'(Signature), 32'(vt[i].sig));
      check($sformatf("vec%0d_pass", i), 32'(BistPass), 32'(vt[i].pass));
      check($sformatf("vec%0d_bus", i), 32'(bus_err), 0);
    end

    // Restart straight from DONE.
    EndAddr = 8'h0F;
    Golden = 16'h0078;
    BistStart = 1'b1;
    tick();
    BistStart = 1'b0;
    #1;
    check("restart_sig_clear", 32'(Signature), 0);
    check("restart_busy", 32'(BistBusy), 1);
    check("restart_done_clear", 32'(BistDone), 0);
    check("restart_pass_clear", 32'(BistPass), 0);
    wait_done(100, done_cyc);
    check("restart_done_cycle", 32'(done_cyc), 18);
    check("restart_sig", 32'(Signature), 32'h78);
    check("restart_pass", 32'(BistPass), 1);

    // Abort at the tenth RUN cycle; sum of ROM[0..8] has accumulated by then.
    EndAddr = 8'hFF;
    Golden = 16'h7F80;
    BistStart = 1'b1;
    tick();
    BistStart = 1'b0;
    repeat (9) tick();
    BistAbort = 1'b1;
    FuncAddress = 8'h5A;
    tick();
    BistAbort = 1'b0;
    #1;
    check("abort_busy", 32'(BistBusy), 0);
    check("abort_done", 32'(BistDone), 0);
    check("abort_romaddr", 32'(RomAddress), 32'h5A);
    check("abort_funcdata", 32'(FuncDataOut), 32'h5A);
    check("abort_sig_held", 32'(Signature), 36);
    stray = 0;
    repeat (5) begin
      tick();
      #1;
      if (BistBusy || BistDone || Signature != 16'd36) stray++;
    end
    check("abort_stays_idle", 32'(stray), 0);

    // Abort from DONE, simultaneous with start: abort wins.
    run_bist(8'h03, 16'h0006, 0, done_cyc, busy_cyc, bus_err);
    check("pre_abort_pass", 32'(BistPass), 1);
    BistAbort = 1'b1;
    BistStart = 1'b1;
    tick();
    BistAbort = 1'b0;
    BistStart = 1'b0;
    #1;
    check("abort_start_busy", 32'(BistBusy), 0);
    check("abort_start_done", 32'(BistDone), 0);
    check("abort_start_pass", 32'(BistPass), 0);
    check("abort_start_sig", 32'(Signature), 6);

    // Asynchronous reset in the middle of RUN.
    EndAddr = 8'hFF;
    BistStart = 1'b1;
    tick();
    BistStart = 1'b0;
    repeat (20) tick();
    FuncAddress = 8'hC3;
    #1 WRSTN = 1'b0;
    #1;
    check("midrst_busy", 32'(BistBusy), 0);
    check("midrst_done", 32'(BistDone), 0);
    check("midrst_pass", 32'(BistPass), 0);
    check("midrst_sig", 32'(Signature), 0);
    check("midrst_romaddr", 32'(RomAddress), 32'hC3);
    tick();
    tick();
    WRSTN = 1'b1;
    stray = 0;
    repeat (10) begin
      FuncAddress = 8'($urandom);
      tick();
      #1;
      if (BistBusy || BistDone || Signature != 16'd0 || RomAddress != FuncAddress) stray++;
    end
    check("midrst_no_activity", 32'(stray), 0);

    // Random ROM contents against a summing reference model.
    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < 256; a++) rom_mem[a] = 8'($urandom);
      r_ea = 8'($urandom_range(0, 255));
      model_sum = 0;
      for (int a = 0; a <= int'(r_ea); a++) model_sum += int'(rom_mem[a]);
      model_sum = model_sum % 65536;
      if ($urandom_range(0, 1) == 1) r_gd = 16'(model_sum);
      else r_gd = 16'(model_sum) ^ (16'h1 << $urandom_range(0, 15));
      r_pass = (r_gd == 16'(model_sum));
      run_bist(r_ea, r_gd, 0, done_cyc, busy_cyc, bus_err);
      check($sformatf("rnd%0d_done_cycle", r), 32'(done_cyc), 32'(int'(r_ea) + 3));
      check($sformatf("rnd%0d_sig", r), 32'(Signature), 32'(model_sum));
      check($sformatf("rnd%0d_pass", r), 32'(BistPass), 32'(r_pass));
      check($sformatf("rnd%0d_bus", r), 32'(bus_err), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
